// File: rtl/sram_burst_master_pkg.sv
// Shared constants and types for the SRAM burst master.
//   DATA_W / ADDR_W / DEPTH / LEN_W : default SRAM geometry and burst length width
//   state_t    : burst FSM states
//   sram_cmd_t : one burst command (direction, base word address, word count)
package sram_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DEPTH  = 128;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } sram_cmd_t;

endpackage

// File: rtl/sram_burst_master_if.sv
// Bus bundle for sram_burst_master.
//   cmd_*   : burst command handshake (valid/ready, write, addr, len)
//   wr_*    : write-data stream into the master
//   rd_*    : read-data stream out of the master
//   sram_*  : SRAM port (addr, wdata, we, re, rdata)
//   busy    : burst in progress; done : one-cycle completion pulse
// modport master : the burst master's view; modport slave : the environment's view.
interface sram_burst_master_if #(
    parameter int unsigned DATA_W = sram_pkg::DATA_W,
    parameter int unsigned ADDR_W = sram_pkg::ADDR_W,
    parameter int unsigned LEN_W  = sram_pkg::LEN_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_we;
    logic              sram_re;
    logic [DATA_W-1:0] sram_rdata;

    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data,
        input  rd_ready,
        output sram_addr, sram_wdata, sram_we, sram_re,
        input  sram_rdata,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data,
        output rd_ready,
        input  sram_addr, sram_wdata, sram_we, sram_re,
        output sram_rdata,
        input  busy, done
    );

endinterface

// File: rtl/sram_burst_master_rd_skid_fifo.sv
// rd_skid_fifo: 2-entry FIFO buffering SRAM read data toward the read stream.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push      : write push_data (ignored when full and not popping)
//   pop       : consume head (ignored when empty)
//   count     : occupancy 0..2
//   head      : oldest entry; stable until popped
module rd_skid_fifo #(
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = ~wptr_q;
        end
        if (do_pop) begin
            rptr_d = ~rptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = mem_q[rptr_q];

endmodule

// File: rtl/sram_burst_master.sv
// sram_burst_master: turns (op, base, len) burst commands into per-word SRAM
// write/read cycles.
//   clk, rst : clock; synchronous active-high reset
//   bus      : sram_burst_master_if.master
//     cmd_*  : command handshake; cmd_len = 0 is a no-op that still pulses done
//     wr_*   : write words, passed combinationally to sram_wdata on handshake
//     rd_*   : read words from a 2-entry buffer, back-pressured by rd_ready
//     sram_* : SRAM port, read data returns one clock after sram_re
//     busy   : FSM not idle; done : one-cycle pulse after a burst completes
module sram_burst_master #(
    parameter int unsigned DATA_W = sram_pkg::DATA_W,
    parameter int unsigned ADDR_W = sram_pkg::ADDR_W,
    parameter int unsigned DEPTH  = sram_pkg::DEPTH,
    parameter int unsigned LEN_W  = sram_pkg::LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    sram_burst_master_if.master bus
);

    import sram_pkg::*;

    localparam int unsigned CUR_W = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [CUR_W-1:0]  cur_q, cur_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;

    sram_cmd_t         cmd;
    logic              cmd_ready, cmd_fire;
    logic              wr_ready, wr_fire;
    logic              rd_issue;
    logic [CUR_W-1:0]  cur_next;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              rd_valid, rd_pop;
    logic [1:0]        occupancy;

    assign cmd = '{write: bus.cmd_write, addr: bus.cmd_addr, len: bus.cmd_len};

    rd_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (bus.sram_rdata),
        .pop       (rd_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        cur_next  = (cur_q == CUR_W'(DEPTH - 1)) ? '0 : cur_q + CUR_W'(1);

        cmd_ready = !rst && (state_q == IDLE);
        cmd_fire  = cmd_ready && bus.cmd_valid;

        wr_ready  = !rst && (state_q == WRITE) && (rem_q != '0);
        wr_fire   = wr_ready && bus.wr_valid;

        rd_valid  = (fifo_count != 2'd0);
        rd_pop    = rd_valid && bus.rd_ready;

        // Words buffered plus the one returning from the SRAM must never
        // exceed the two FIFO slots; a pop this cycle frees one slot in time.
        occupancy = fifo_count + {1'b0, inflight_q};
        rd_issue  = !rst && (state_q == READ) && (rem_q != '0) &&
                    ((occupancy < 2'd2) || ((occupancy == 2'd2) && rd_pop));
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rem_d      = rem_q;
        inflight_d = rd_issue;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    cur_d = CUR_W'(cmd.addr % ADDR_W'(DEPTH));
                    rem_d = cmd.len;
                    if (cmd.len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = cmd.write ? WRITE : READ;
                    end
                end
            end
            WRITE: begin
                if (wr_fire) begin
                    cur_d = cur_next;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_issue) begin
                    cur_d = cur_next;
                    rem_d = rem_q - LEN_W'(1);
                end
                // Nothing left to issue or return: finish as the last word leaves.
                if ((rem_q == '0) && !inflight_q && (fifo_count == 2'd1) && rd_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.wr_ready   = wr_ready;
    assign bus.sram_we    = wr_fire;
    assign bus.sram_re    = rd_issue;
    assign bus.sram_addr  = ADDR_W'(cur_q);
    assign bus.sram_wdata = bus.wr_data;
    assign bus.rd_valid   = rd_valid;
    assign bus.rd_data    = fifo_head;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_sram_burst_master.sv
// Self-checking bench for sram_burst_master with a behavioural 1-clk-latency SRAM.
module tb_sram_burst_master;

    logic clk;
    logic rst;
    int   cyc;

    sram_burst_master_if #(.DATA_W(24), .ADDR_W(24), .LEN_W(8)) bus ();

    sram_burst_master #(
        .DATA_W (24),
        .ADDR_W (24),
        .DEPTH  (128),
        .LEN_W  (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM, read data one clock after sram_re.
    logic [23:0] sram_mem [128];
    logic [23:0] sram_rdata_q;
    always @(posedge clk) begin
        if (bus.sram_we) sram_mem[bus.sram_addr[6:0]] <= bus.sram_wdata;
        if (bus.sram_re) sram_rdata_q <= sram_mem[bus.sram_addr[6:0]];
    end
    assign bus.sram_rdata = sram_rdata_q;

    typedef struct {
        logic [23:0] addr;
        logic [23:0] data;
    } wexp_t;

    typedef struct {
        bit          wr;
        logic [23:0] addr;
        int unsigned len;
        bit          stall;
        int          lat;     // expected done cycle minus accept cycle, -1 = unchecked
    } vec_t;

    wexp_t       exp_wr [$];
    logic [23:0] exp_ra [$];
    logic [23:0] exp_rd [$];
    logic [23:0] ref_mem [128];
    logic [23:0] next_data;

    int total, bad;
    int done_cnt, done_cyc, we_cnt, re_cnt, pop_cnt;
    int occ;
    bit          prev_stall;
    logic [23:0] prev_data;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s got=unexpected-event exp=none t=%0t", name, $time);
    endtask

    task automatic monitor();
        wexp_t       w;
        logic [23:0] a;
        bit          re, pop;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rst) begin
                occ        = 0;
                prev_stall = 0;
            end else begin
                re  = (bus.sram_re === 1'b1);
                pop = (bus.rd_valid === 1'b1) && (bus.rd_ready === 1'b1);
                if (bus.sram_we || re) check("we_re_exclusive", {31'd0, bus.sram_we & bus.sram_re}, 0);
                if (bus.busy === 1'b1) check("cmd_ready_busy", {31'd0, bus.cmd_ready}, 0);
                if (bus.sram_we === 1'b1) begin
                    we_cnt++;
                    if (exp_wr.size() == 0) note_fail("we_extra");
                    else begin
                        w = exp_wr.pop_front();
                        check("we_addr", {8'd0, bus.sram_addr}, {8'd0, w.addr});
                        check("we_data", {8'd0, bus.sram_wdata}, {8'd0, w.data});
                    end
                end
                if (re) begin
                    re_cnt++;
                    check("outstanding_le2", {31'd0, (occ + 1 - (pop ? 1 : 0)) <= 2}, 1);
                    if (exp_ra.size() == 0) note_fail("re_extra");
                    else begin
                        a = exp_ra.pop_front();
                        check("re_addr", {8'd0, bus.sram_addr}, {8'd0, a});
                    end
                end
                if (prev_stall) begin
                    check("rd_hold_valid", {31'd0, bus.rd_valid}, 1);
                    check("rd_hold_data", {8'd0, bus.rd_data}, {8'd0, prev_data});
                end
                if (pop) begin
                    pop_cnt++;
                    if (exp_rd.size() == 0) note_fail("rd_extra");
                    else begin
                        a = exp_rd.pop_front();
                        check("rd_data", {8'd0, bus.rd_data}, {8'd0, a});
                    end
                end
                occ        = occ + (re ? 1 : 0) - (pop ? 1 : 0);
                prev_stall = (bus.rd_valid === 1'b1) && (bus.rd_ready !== 1'b1);
                prev_data  = bus.rd_data;
            end
        end
    endtask

    task automatic wait_done(input int done0);
        for (int k = 0; k < 100 && done_cnt == done0; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_cmd(input bit wr, input logic [23:0] addr, input int unsigned len,
                           input bit stall, input int lat);
        logic [23:0] d [$];
        logic [23:0] a;
        int acc, done0, we0, re0, pop0, n;
        for (int unsigned i = 0; i < len; i++) begin
            a = (addr % 128 + i) % 128;
            if (wr) begin
                d.push_back(next_data);
                exp_wr.push_back('{addr: a, data: next_data});
                ref_mem[a[6:0]] = next_data;
                next_data = next_data + 24'h1;
            end else begin
                exp_ra.push_back(a);
                exp_rd.push_back(ref_mem[a[6:0]]);
            end
        end
        done0 = done_cnt; we0 = we_cnt; re0 = re_cnt; pop0 = pop_cnt;
        @(posedge clk); #1;
        bus.rd_ready  = !stall;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = 8'(len);
        @(negedge clk);
        check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 1);
        @(posedge clk); #1;
        acc = cyc;
        bus.cmd_valid = 1'b0;
        if (wr) begin
            for (int unsigned i = 0; i < len; i++) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = d[i];
                n = 0;
                @(negedge clk);
                while (bus.wr_ready !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk); #1;
            end
            bus.wr_valid = 1'b0;
        end else if (stall) begin
            for (int k = 0; k < 400 && (pop_cnt - pop0) < int'(len); k++) begin
                @(posedge clk); #1;
                bus.rd_ready = 1'($urandom_range(0, 1));
            end
        end
        wait_done(done0);
        bus.rd_ready = 1'b1;
        check("done_pulse", done_cnt - done0, 1);
        if (lat >= 0) check("done_latency", done_cyc - acc, lat);
        if (len == 0) check("len0_cmd_ready", {31'd0, bus.cmd_ready}, 1);
        check("we_count", we_cnt - we0, wr ? len : 0);
        check("re_count", re_cnt - re0, wr ? 0 : len);
        check("rd_words", pop_cnt - pop0, wr ? 0 : len);
        check("queues_drained", exp_wr.size() + exp_ra.size() + exp_rd.size(), 0);
    endtask

    task automatic main();
        vec_t vecs [10];
        int   done0, pop0;
        vecs[0] = '{wr: 1'b1, addr: 24'd5,       len: 6, stall: 1'b0, lat: 6};
        vecs[1] = '{wr: 1'b0, addr: 24'd5,       len: 4, stall: 1'b0, lat: 6};
        vecs[2] = '{wr: 1'b0, addr: 24'd5,       len: 6, stall: 1'b1, lat: -1};
        vecs[3] = '{wr: 1'b1, addr: 24'd126,     len: 4, stall: 1'b0, lat: 4};
        vecs[4] = '{wr: 1'b0, addr: 24'd126,     len: 4, stall: 1'b0, lat: 6};
        vecs[5] = '{wr: 1'b1, addr: 24'd40,      len: 0, stall: 1'b0, lat: 0};
        vecs[6] = '{wr: 1'b0, addr: 24'd40,      len: 0, stall: 1'b0, lat: 0};
        vecs[7] = '{wr: 1'b0, addr: 24'h000085,  len: 2, stall: 1'b0, lat: 4};
        vecs[8] = '{wr: 1'b1, addr: 24'hFFFF7F,  len: 1, stall: 1'b0, lat: 1};
        vecs[9] = '{wr: 1'b0, addr: 24'd127,     len: 1, stall: 1'b0, lat: 3};

        // Reset with stimulus asserted: handshakes and SRAM strobes must stay low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 0);
        check("rst_wr_ready",  {31'd0, bus.wr_ready}, 0);
        check("rst_sram_we",   {31'd0, bus.sram_we}, 0);
        check("rst_sram_re",   {31'd0, bus.sram_re}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        @(negedge clk);
        check("reset_busy",      {31'd0, bus.busy}, 0);
        check("reset_done",      {31'd0, bus.done}, 0);
        check("reset_rd_valid",  {31'd0, bus.rd_valid}, 0);
        check("reset_cmd_ready", {31'd0, bus.cmd_ready}, 1);

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].stall, vecs[i].lat);
        end

        // Reset in the middle of a 6-word read after two words were delivered.
        pop0 = pop_cnt;
        for (int unsigned i = 0; i < 6; i++) begin
            exp_ra.push_back(24'(5 + i));
            exp_rd.push_back(ref_mem[7'(5 + i)]);
        end
        @(posedge clk); #1;
        bus.rd_ready  = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 24'd5;
        bus.cmd_len   = 8'd6;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 50 && (pop_cnt - pop0) < 2; k++) begin
            @(negedge clk); #1;
        end
        check("midrst_two_words", pop_cnt - pop0, 2);
        @(posedge clk); #1;
        rst   = 1'b1;
        done0 = done_cnt;
        @(negedge clk); #1;
        check("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 0);
        check("midrst_sram_re",   {31'd0, bus.sram_re}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ra.delete();
        exp_rd.delete();
        check("midrst_rd_valid", {31'd0, bus.rd_valid}, 0);
        check("midrst_busy",     {31'd0, bus.busy}, 0);
        repeat (3) @(negedge clk);
        #1;
        check("midrst_no_done", done_cnt - done0, 0);

        run_cmd(1'b1, 24'd20, 2, 1'b0, 2);
        run_cmd(1'b0, 24'd20, 2, 1'b0, 4);
    endtask

    initial begin
        rst           = 1'b1;
        cyc           = 0;
        total         = 0;
        bad           = 0;
        done_cnt      = 0;
        done_cyc      = 0;
        we_cnt        = 0;
        re_cnt        = 0;
        pop_cnt       = 0;
        occ           = 0;
        prev_stall    = 0;
        prev_data     = '0;
        next_data     = 24'hA00000;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 24'd3;
        bus.cmd_len   = 8'd3;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 24'h123456;
        bus.rd_ready  = 1'b1;
        fork
            monitor();
            main();
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
